// File: rtl/wallace_pkg.sv
// ============================================================================
// Module : wallace_pkg
// Desc   : Shared sizing functions and stage control type for the CSA adder tree
// Rev    : 1.0
// ============================================================================
`default_nettype none

package wallace_pkg;

  typedef struct packed {
    logic valid;
    logic is_signed;
  } stage_ctrl_t;

  // Operand count left after one 3:2 layer; counts of two or fewer are final.
  function automatic int wal_next_n(input int n);
    if (n <= 2) return n;
    return 3 * (n / 3) + n % 3 - n / 3;
  endfunction

  function automatic int wal_n_after(input int n, input int k);
    int m;
    m = n;
    for (int i = 0; i < k; i++) m = wal_next_n(m);
    return m;
  endfunction

  function automatic int wal_layers(input int n);
    int m;
    int l;
    m = n;
    l = 0;
    while (m > 2) begin
      m = wal_next_n(m);
      l++;
    end
    return l;
  endfunction

  function automatic int wal_stages(input int n, input int r);
    return (wal_layers(n) + r - 1) / r;
  endfunction

  // At least one guard bit so a single sign-extended operand stays exact.
  function automatic int wal_iw(input int di_w, input int d_n);
    int w;
    w = di_w + $clog2(d_n);
    return (w < di_w + 1) ? di_w + 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/csa_layer.sv
// ============================================================================
// Module : csa_layer
// Desc   : One 3:2 carry-save layer; output order is remainders, sums, carries
// Rev    : 1.0
// ============================================================================
`default_nettype none

module csa_layer
  import wallace_pkg::*;
#(
  parameter int IW = 21,
  parameter int N  = 3
) (
  input  logic [N*IW-1:0]             i_words,
  output logic [wal_next_n(N)*IW-1:0] o_words
);

  localparam int G = N / 3;
  localparam int R = N % 3;

  for (genvar r = 0; r < R; r++) begin : g_pass
    assign o_words[r*IW +: IW] = i_words[(3*G+r)*IW +: IW];
  end

  for (genvar g = 0; g < G; g++) begin : g_grp
    logic [IW-1:0] a;
    logic [IW-1:0] b;
    logic [IW-1:0] c;
    logic [IW-2:0] maj;

    assign a = i_words[(3*g)*IW   +: IW];
    assign b = i_words[(3*g+1)*IW +: IW];
    assign c = i_words[(3*g+2)*IW +: IW];

    // The carry out of the top bit falls off the IW-bit word by design.
    assign maj = (a[IW-2:0] & b[IW-2:0]) | (a[IW-2:0] & c[IW-2:0]) | (b[IW-2:0] & c[IW-2:0]);

    assign o_words[(R+g)*IW   +: IW] = a ^ b ^ c;
    assign o_words[(R+G+g)*IW +: IW] = {maj, 1'b0};
  end

endmodule

`default_nettype wire

// File: rtl/wallace_pipe_adder.sv
// ============================================================================
// Module : wallace_pipe_adder
// Desc   : Pipelined multi-operand adder, 3:2 CSA tree + CPA, valid/ready flow
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wallace_pipe_adder
  import wallace_pkg::*;
#(
  parameter int DI_W      = 16,
  parameter int D_N       = 28,
  parameter int DO_W      = 21,
  parameter int REG_EVERY = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_signed,
  input  logic [D_N*DI_W-1:0]  i_add_i,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DO_W-1:0]      o_sum,
  output logic                 o_ovf
);

  localparam int IW = wal_iw(DI_W, D_N);
  localparam int L  = wal_layers(D_N);
  localparam int NL = wal_n_after(D_N, L);

  logic              en;
  logic [IW-1:0]     lvl_w [L+1][D_N];
  stage_ctrl_t       lvl_c [L+1];

  logic              valid_d, valid_q;
  logic [DO_W-1:0]   sum_d, sum_q;
  logic              ovf_d, ovf_q;

  // One global enable: the whole pipe freezes while a result waits downstream.
  assign en      = !valid_q || i_ready;
  assign o_ready = en;

  for (genvar k = 0; k < D_N; k++) begin : g_ext
    logic [DI_W-1:0] op;
    assign op          = i_add_i[k*DI_W +: DI_W];
    assign lvl_w[0][k] = {{(IW-DI_W){i_signed & op[DI_W-1]}}, op};
  end

  assign lvl_c[0] = '{valid: i_valid, is_signed: i_signed};

  for (genvar k = 0; k < L; k++) begin : g_layer
    localparam int  N_IN     = wal_n_after(D_N, k);
    localparam int  N_OUT    = wal_next_n(N_IN);
    localparam bit  REG_HERE = ((k + 1) % REG_EVERY == 0) || (k == L - 1);

    logic [N_IN*IW-1:0]  in_bus;
    logic [N_OUT*IW-1:0] csa_out;
    logic [N_OUT*IW-1:0] out_bus;

    for (genvar j = 0; j < N_IN; j++) begin : g_in
      assign in_bus[j*IW +: IW] = lvl_w[k][j];
    end

    csa_layer #(
      .IW (IW),
      .N  (N_IN)
    ) u_csa (
      .i_words (in_bus),
      .o_words (csa_out)
    );

    if (REG_HERE) begin : g_reg
      logic [N_OUT*IW-1:0] data_d, data_q;
      stage_ctrl_t         ctrl_d, ctrl_q;

      always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (en) begin
          data_d = csa_out;
          ctrl_d = lvl_c[k];
        end
      end

      // Only the control bits need reset; data is qualified by valid.
      always_ff @(posedge i_clk) begin
        data_q <= data_d;
        if (i_rst) ctrl_q <= '0;
        else       ctrl_q <= ctrl_d;
      end

      assign out_bus    = data_q;
      assign lvl_c[k+1] = ctrl_q;
    end else begin : g_comb
      assign out_bus    = csa_out;
      assign lvl_c[k+1] = lvl_c[k];
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_out
      assign lvl_w[k+1][j] = out_bus[j*IW +: IW];
    end
  end

  logic [IW-1:0]   cpa_b;
  logic [IW-1:0]   cpa;
  logic [DO_W-1:0] sum_w;
  logic            ovf_w;

  if (NL >= 2) begin : g_cpa2
    assign cpa_b = lvl_w[L][1];
  end else begin : g_cpa1
    assign cpa_b = '0;
  end

  assign cpa = lvl_w[L][0] + cpa_b;

  if (DO_W > IW) begin : g_wide
    assign sum_w = {{(DO_W-IW){lvl_c[L].is_signed & cpa[IW-1]}}, cpa};
    assign ovf_w = 1'b0;
  end else if (DO_W == IW) begin : g_equal
    assign sum_w = cpa;
    assign ovf_w = 1'b0;
  end else begin : g_narrow
    // top spans the discarded bits plus the result's sign bit.
    logic [IW-DO_W:0] top;
    assign top   = cpa[IW-1:DO_W-1];
    assign sum_w = cpa[DO_W-1:0];
    assign ovf_w = lvl_c[L].is_signed ? !((&top) || !(|top)) : (|top[IW-DO_W:1]);
  end

  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    if (en) begin
      valid_d = lvl_c[L].valid;
      if (lvl_c[L].valid) begin
        sum_d = sum_w;
        ovf_d = ovf_w;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_valid = valid_q;
  assign o_sum   = sum_q;
  assign o_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_wallace_pipe_adder.sv
// ============================================================================
// Module : tb_wallace_pipe_adder
// Desc   : Directed + random bench; 21-bit and 16-bit result instances side by side
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_wallace_pipe_adder;

  localparam int DI_W = 16;
  localparam int D_N  = 28;
  localparam int LAT  = 5;
  localparam int OPW  = D_N * DI_W;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_valid, i_signed, i_ready;
  logic [OPW-1:0] ops;

  logic           o_ready, o_valid, o_ovf;
  logic [20:0]    o_sum;
  logic           n_ready, n_valid, n_ovf;
  logic [15:0]    n_sum;

  always #5 clk = ~clk;

  wallace_pipe_adder #(.DI_W(DI_W), .D_N(D_N), .DO_W(21), .REG_EVERY(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_signed(i_signed),
    .i_add_i(ops), .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_ovf(o_ovf)
  );

  wallace_pipe_adder #(.DI_W(DI_W), .D_N(D_N), .DO_W(16), .REG_EVERY(2)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(n_ready), .i_signed(i_signed),
    .i_add_i(ops), .o_valid(n_valid), .i_ready(i_ready), .o_sum(n_sum), .o_ovf(n_ovf)
  );

  typedef struct {
    bit        v;
    bit [20:0] s21;
    bit        o21;
    bit [15:0] s16;
    bit        o16;
  } slot_t;

  slot_t pipe [LAT];
  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  int n_out    = 0;
  int n_lost   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // True integer sum under the transaction's mode, then reduced per result width.
  function automatic slot_t model(input bit v, input bit s, input logic [OPW-1:0] d);
    slot_t      r;
    longint     tot;
    logic [15:0] w;
    tot = 0;
    for (int k = 0; k < D_N; k++) begin
      w = d[k*DI_W +: DI_W];
      tot += s ? longint'($signed(w)) : longint'(w);
    end
    r.v   = v;
    r.s21 = tot[20:0];
    r.o21 = s ? (tot < -64'sd1048576 || tot >= 64'sd1048576) : (tot >= 64'sd2097152);
    r.s16 = tot[15:0];
    r.o16 = s ? (tot < -64'sd32768 || tot >= 64'sd32768) : (tot >= 64'sd65536);
    return r;
  endfunction

  function automatic logic [OPW-1:0] rnd_ops();
    logic [OPW-1:0] d;
    for (int k = 0; k < D_N; k++) d[k*DI_W +: DI_W] = 16'($urandom);
    return d;
  endfunction

  function automatic logic [OPW-1:0] fill_ops(input logic [15:0] val);
    logic [OPW-1:0] d;
    for (int k = 0; k < D_N; k++) d[k*DI_W +: DI_W] = val;
    return d;
  endfunction

  task automatic step(input bit v, input bit s, input logic [OPW-1:0] d, input bit rdy);
    bit    en_m;
    slot_t nw;
    i_valid  = v;
    i_signed = s;
    ops      = d;
    i_ready  = rdy;
    #1;
    en_m = !pipe[LAT-1].v || rdy;
    chk("o_ready", o_ready, en_m);
    chk("o_ready16", n_ready, en_m);
    nw = model(v, s, d);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        if (pipe[i].v) n_lost++;
        pipe[i].v = 1'b0;
      end
    end else if (en_m) begin
      if (v) n_acc++;
      if (pipe[LAT-1].v) n_out++;
      for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = nw;
    end
    #1;
    chk("o_valid", o_valid, pipe[LAT-1].v);
    chk("o_valid16", n_valid, pipe[LAT-1].v);
    if (pipe[LAT-1].v) begin
      chk("o_sum", o_sum, pipe[LAT-1].s21);
      chk("o_ovf", o_ovf, pipe[LAT-1].o21);
      chk("o_sum16", n_sum, pipe[LAT-1].s16);
      chk("o_ovf16", n_ovf, pipe[LAT-1].o16);
    end
  endtask

  initial begin
    logic [OPW-1:0] d;
    bit             s;

    rst      = 1'b1;
    i_valid  = 1'b0;
    i_signed = 1'b0;
    i_ready  = 1'b1;
    ops      = '0;
    for (int i = 0; i < LAT; i++) pipe[i] = '{default: 0};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_sum", o_sum, 21'h0);
    chk("rst_ovf", o_ovf, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_sum16", n_sum, 16'h0);
    chk("rst_ovf16", n_ovf, 1'b0);

    // Unsigned full scale: result lands exactly LAT cycles after accept.
    step(1'b1, 1'b0, fill_ops(16'hFFFF), 1'b1);
    repeat (LAT - 1) step(1'b0, 1'b0, '0, 1'b1);
    chk("fs_sum", o_sum, 21'h1BFFE4);
    chk("fs_ovf", o_ovf, 1'b0);
    chk("fs_sum16", n_sum, 16'hFFE4);
    chk("fs_ovf16", n_ovf, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Signed minimum.
    step(1'b1, 1'b1, fill_ops(16'h8000), 1'b1);
    repeat (LAT - 1) step(1'b0, 1'b0, '0, 1'b1);
    chk("smin_sum", o_sum, 21'h120000);
    chk("smin_ovf", o_ovf, 1'b0);
    chk("smin_ovf16", n_ovf, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Back-to-back stream with the mode toggling every cycle.
    for (int i = 0; i < 10; i++) step(1'b1, 1'(i % 2), rnd_ops(), 1'b1);
    repeat (LAT) step(1'b0, 1'b0, '0, 1'b1);

    // Backpressure: hold one input valid through a 7-cycle downstream stall.
    for (int i = 0; i < 5; i++) step(1'b1, 1'(i % 2), rnd_ops(), 1'b1);
    d = rnd_ops();
    repeat (7) step(1'b1, 1'b1, d, 1'b0);
    step(1'b1, 1'b1, d, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'(i % 2), rnd_ops(), 1'b1);
    repeat (LAT + 1) step(1'b0, 1'b0, '0, 1'b1);

    // Reset mid-flight drops everything in the pipe.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rnd_ops(), 1'b1);
    rst = 1'b1;
    step(1'b0, 1'b0, '0, 1'b1);
    rst = 1'b0;
    repeat (LAT + 1) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, rnd_ops(), 1'b1);
    repeat (LAT) step(1'b0, 1'b0, '0, 1'b1);

    // Random valid/ready traffic.
    for (int i = 0; i < 80; i++) begin
      s = 1'($urandom);
      step(($urandom % 4) != 0, s, rnd_ops(), ($urandom % 3) != 0);
    end
    repeat (2 * LAT) step(1'b0, 1'b0, '0, 1'b1);

    chk("drain_count", 64'(n_out), 64'(n_acc - n_lost));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
